// File: rtl/risc_cpu_p.sv
// Fetch/execute controller core: 16-bit instructions, parametrised data width,
// ready-handshaked I/O bus, carry/zero flags and a bounded hardware return stack.
//
// state   | meaning
// FETCH   | pc on o_imem_addr, ROM word arrives next cycle
// EXEC    | decode and execute the ROM word, commit rd/flags/pc/sp
// BUS     | registered strobe held until i_bus_ready
// HALT    | HALT executed, idle until reset
// FAULT   | return-stack overflow/underflow, idle until reset
module risc_cpu_p #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [11:0]       o_imem_addr,
  input  logic [15:0]       i_imem_data,
  output logic [ADDR_W-1:0] o_bus_address,
  output logic [DATA_W-1:0] o_bus_data,
  input  logic [DATA_W-1:0] i_bus_data,
  output logic              o_bus_read,
  output logic              o_bus_write,
  input  logic              i_bus_ready,
  output logic              o_halt,
  output logic              o_fault
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_BUS, S_HALT, S_FAULT} state_t;

  state_t state, state_nx;

  logic [11:0]       pc, pc_inc, pc_nx;
  logic [SP_W-1:0]   sp;
  logic              z_flag, c_flag;
  logic [DATA_W-1:0] regs [16];
  logic [11:0]       stack [0:(2**SP_W)-1];

  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_wr;
  logic [3:0]        bus_rd_dst;

  logic [1:0]  cls, sub;
  logic [3:0]  rd, rs1, rs2;
  logic [7:0]  imm;
  logic [11:0] tgt;

  assign cls = i_imem_data[15:14];
  assign sub = i_imem_data[13:12];
  assign rd  = i_imem_data[11:8];
  assign rs1 = i_imem_data[7:4];
  assign rs2 = i_imem_data[3:0];
  assign imm = i_imem_data[7:0];
  assign tgt = i_imem_data[11:0];

  logic is_halt, is_un, is_ret, un_wr, is_li, is_out, is_in, is_alu;
  logic is_jsr, is_jmp, is_beq, is_bnz;

  assign is_halt = (cls == 2'd0) && (sub == 2'd1);
  assign is_un   = (cls == 2'd0) && (sub == 2'd3);
  assign is_ret  = is_un && (rs2 == 4'hF);
  assign un_wr   = is_un && (rs2[3:2] == 2'b00);
  assign is_li   = (cls == 2'd1) && (sub == 2'd0);
  assign is_out  = (cls == 2'd1) && (sub == 2'd1);
  assign is_in   = (cls == 2'd1) && (sub == 2'd2);
  assign is_alu  = (cls == 2'd2);
  assign is_jsr  = (cls == 2'd3) && (sub == 2'd0);
  assign is_jmp  = (cls == 2'd3) && (sub == 2'd1);
  assign is_beq  = (cls == 2'd3) && (sub == 2'd2);
  assign is_bnz  = (cls == 2'd3) && (sub == 2'd3);

  logic stk_full, stk_empty, stk_fault, do_push, do_pop;

  assign stk_full  = (sp == SP_W'(STACK_DEPTH));
  assign stk_empty = (sp == '0);
  assign stk_fault = (is_jsr && stk_full) || (is_ret && stk_empty);
  assign do_push   = (state == S_EXEC) && is_jsr && !stk_full;
  assign do_pop    = (state == S_EXEC) && is_ret && !stk_empty;

  logic [DATA_W-1:0] op_a, op_b, alu_res, un_res, wr_val;
  logic [DATA_W:0]   sum;
  logic              alu_c, wr_en;

  assign op_a = regs[rs1];
  assign op_b = regs[rs2];
  assign sum  = {1'b0, op_a} + {1'b0, op_b};

  always_comb begin
    alu_c = 1'b0;
    case (sub)
      2'd0:    alu_res = op_a ^ op_b;
      2'd1:    alu_res = op_a | op_b;
      2'd2:    alu_res = op_a & op_b;
      default: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
    endcase
  end

  always_comb begin
    case (rs2[1:0])
      2'd0:    un_res = op_a << 1;
      2'd1:    un_res = op_a >> 1;
      2'd2:    un_res = {op_a[DATA_W-2:0], op_a[DATA_W-1]};
      default: un_res = {op_a[0], op_a[DATA_W-1:1]};
    endcase
  end

  always_comb begin
    wr_en  = is_li || is_alu || un_wr;
    wr_val = un_res;
    if (is_li)       wr_val = DATA_W'(imm);
    else if (is_alu) wr_val = alu_res;
  end

  assign pc_inc = pc + 12'd1;

  // A faulting call/return or HALT leaves pc where it is.
  always_comb begin
    pc_nx = pc_inc;
    if (is_halt || stk_fault)
      pc_nx = pc;
    else if (is_ret)
      pc_nx = stack[sp - SP_W'(1)];
    else if (is_jsr || is_jmp || (is_beq && z_flag) || (is_bnz && !z_flag))
      pc_nx = tgt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: state_nx = S_EXEC;
      S_EXEC: begin
        if (is_halt)              state_nx = S_HALT;
        else if (stk_fault)       state_nx = S_FAULT;
        else if (is_out || is_in) state_nx = S_BUS;
        else                      state_nx = S_FETCH;
      end
      S_BUS:   if (i_bus_ready) state_nx = S_FETCH;
      default: state_nx = state;
    endcase
  end

  always_comb begin
    o_bus_read  = (state == S_BUS) && !bus_wr;
    o_bus_write = (state == S_BUS) && bus_wr;
    o_halt      = (state == S_HALT);
    o_fault     = (state == S_FAULT);
  end

  assign o_imem_addr   = pc;
  assign o_bus_address = bus_addr;
  assign o_bus_data    = bus_wdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc         <= '0;
      sp         <= '0;
      z_flag     <= 1'b0;
      c_flag     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wr     <= 1'b0;
      bus_rd_dst <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (state == S_EXEC) begin
      pc <= pc_nx;
      if (wr_en) regs[rd] <= wr_val;
      if (is_alu) begin
        z_flag <= (alu_res == '0);
        c_flag <= alu_c;
      end
      if (do_push) sp <= sp + SP_W'(1);
      if (do_pop)  sp <= sp - SP_W'(1);
      if (is_out || is_in) begin
        bus_addr   <= op_a[ADDR_W-1:0];
        bus_wdata  <= is_out ? op_b : '0;
        bus_wr     <= is_out;
        bus_rd_dst <= rd;
      end
    end else if ((state == S_BUS) && i_bus_ready && !bus_wr) begin
      regs[bus_rd_dst] <= i_bus_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && do_push) stack[sp] <= pc_inc;
  end

endmodule

// File: tb/tb_risc_cpu_p.sv
// Directed bench for risc_cpu_p: 8-bit instance for ALU/branch/stack/bus cases,
// 16-bit instance for zero-extension, wide carry and reset during a bus transfer.
module tb_risc_cpu_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, rst16;
  logic [11:0] ia8, ia16;
  logic [15:0] id8, id16;
  logic [7:0]  ba8, ba16;
  logic [7:0]  bdo8, bdi8;
  logic [15:0] bdo16, bdi16;
  logic        brd8, bwr8, rdy8, halt8, fault8;
  logic        brd16, bwr16, rdy16, halt16, fault16;

  risc_cpu_p #(.DATA_W(8), .ADDR_W(8), .STACK_DEPTH(4)) dut8 (
    .i_clk(clk), .i_rst(rst8), .o_imem_addr(ia8), .i_imem_data(id8),
    .o_bus_address(ba8), .o_bus_data(bdo8), .i_bus_data(bdi8),
    .o_bus_read(brd8), .o_bus_write(bwr8), .i_bus_ready(rdy8),
    .o_halt(halt8), .o_fault(fault8));

  risc_cpu_p #(.DATA_W(16), .ADDR_W(8), .STACK_DEPTH(4)) dut16 (
    .i_clk(clk), .i_rst(rst16), .o_imem_addr(ia16), .i_imem_data(id16),
    .o_bus_address(ba16), .o_bus_data(bdo16), .i_bus_data(bdi16),
    .o_bus_read(brd16), .o_bus_write(bwr16), .i_bus_ready(rdy16),
    .o_halt(halt16), .o_fault(fault16));

  logic [15:0] rom8  [4096];
  logic [15:0] rom16 [4096];
  always @(posedge clk) begin
    id8  <= rom8[ia8];
    id16 <= rom16[ia16];
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          len;
    bit          wr;
    bit          stable;
  } xfer_t;

  xfer_t xq8[$], xq16[$];
  xfer_t cur8, cur16;
  bit    act8 = 0, act16 = 0, both8 = 0;
  int    wait8 = 0, wait16 = 0;

  // Bus slave: records each transfer, releases ready after wait cycles.
  always @(negedge clk) begin
    if (bwr8 && brd8) both8 = 1;
    if (bwr8 || brd8) begin
      if (!act8) begin
        act8 = 1;
        cur8.addr = 16'(ba8); cur8.data = 16'(bdo8);
        cur8.len = 1; cur8.wr = bwr8; cur8.stable = 1;
      end else begin
        cur8.len++;
        if (cur8.addr != 16'(ba8) || cur8.data != 16'(bdo8) || cur8.wr != bwr8)
          cur8.stable = 0;
      end
      rdy8 = (cur8.len > wait8);
    end else begin
      if (act8) begin xq8.push_back(cur8); act8 = 0; end
      rdy8 = 1'b0;
    end
    if (bwr16 || brd16) begin
      if (!act16) begin
        act16 = 1;
        cur16.addr = 16'(ba16); cur16.data = bdo16;
        cur16.len = 1; cur16.wr = bwr16; cur16.stable = 1;
      end else begin
        cur16.len++;
        if (cur16.addr != 16'(ba16) || cur16.data != bdo16) cur16.stable = 0;
      end
      rdy16 = (cur16.len > wait16);
    end else begin
      if (act16) begin xq16.push_back(cur16); act16 = 0; end
      rdy16 = 1'b0;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clr8();
    for (int i = 0; i < 4096; i++) rom8[i] = 16'h0000;
  endtask

  task automatic clr16();
    for (int i = 0; i < 4096; i++) rom16[i] = 16'h0000;
  endtask

  task automatic run8(input int max_cyc, output int cyc);
    rst8 = 1'b1;
    repeat (2) @(negedge clk);
    xq8.delete();
    rst8 = 1'b0;
    cyc = 0;
    while (cyc < max_cyc && !halt8 && !fault8) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run16(input int max_cyc, output int cyc);
    rst16 = 1'b1;
    repeat (2) @(negedge clk);
    xq16.delete();
    rst16 = 1'b0;
    cyc = 0;
    while (cyc < max_cyc && !halt16 && !fault16) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // op is encoded with rd=r3, rs1=r1, rs2=r2; z/c are the flags after the op.
  typedef struct {
    logic [15:0] op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  res;
    logic        z;
    logic        c;
  } vec_t;

  vec_t vt[12];
  int   cyc;
  int   n;

  initial begin
    vt[0]  = '{16'hB312, 8'h05, 8'hFB, 8'h00, 1'b1, 1'b1};  // ADD wraps to zero
    vt[1]  = '{16'hB312, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    vt[2]  = '{16'hB312, 8'hFF, 8'h02, 8'h01, 1'b0, 1'b1};
    vt[3]  = '{16'h8312, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0};  // XOR
    vt[4]  = '{16'h9312, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0};  // OR
    vt[5]  = '{16'hA312, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b0};  // AND clears prior C
    vt[6]  = '{16'h8312, 8'hFF, 8'h80, 8'h7F, 1'b0, 1'b0};
    vt[7]  = '{16'h3313, 8'h01, 8'h80, 8'h80, 1'b1, 1'b1};  // ROR, flags kept
    vt[8]  = '{16'h3311, 8'h80, 8'h01, 8'h40, 1'b0, 1'b0};  // SHR
    vt[9]  = '{16'h3310, 8'h81, 8'h80, 8'h02, 1'b1, 1'b1};  // SHL
    vt[10] = '{16'h3312, 8'h81, 8'h01, 8'h03, 1'b0, 1'b0};  // ROL
    vt[11] = '{16'h3315, 8'h55, 8'h80, 8'h00, 1'b1, 1'b1};  // unary NOP

    rst8 = 1'b1; rst16 = 1'b1;
    bdi8 = 8'h3C; bdi16 = 16'h0000;
    clr8(); clr16();
    repeat (3) @(negedge clk);
    chk("rst_imem_addr", 32'(ia8), 32'h0);
    chk("rst_strobes", {30'd0, brd8, bwr8}, 32'h0);
    chk("rst_halt_fault", {30'd0, halt8, fault8}, 32'h0);
    chk("rst_bus_addr_data", {16'(ba8), 16'(bdo8)}, 32'h0);

    // Template: r1=a, r2=b, r7=b+b sets flags, op, report result and Z.
    for (int i = 0; i < 12; i++) begin
      clr8();
      rom8[0]  = 16'h4100 | 16'(vt[i].a);
      rom8[1]  = 16'h4200 | 16'(vt[i].b);
      rom8[2]  = 16'hB722;
      rom8[3]  = vt[i].op;
      rom8[4]  = 16'h4520;
      rom8[5]  = 16'h5053;
      rom8[6]  = 16'hE009;
      rom8[7]  = 16'h4600;
      rom8[8]  = 16'hD00A;
      rom8[9]  = 16'h4601;
      rom8[10] = 16'h4521;
      rom8[11] = 16'h5056;
      rom8[12] = 16'h1000;
      run8(200, cyc);
      chk($sformatf("vec%0d_halt", i), 32'(halt8), 32'h1);
      chk($sformatf("vec%0d_nwrites", i), 32'(xq8.size()), 32'd2);
      if (xq8.size() >= 2) begin
        chk($sformatf("vec%0d_res", i), {xq8[0].addr, xq8[0].data}, {16'h0020, 16'(vt[i].res)});
        chk($sformatf("vec%0d_z", i), {xq8[1].addr, xq8[1].data}, {16'h0021, 15'd0, vt[i].z});
      end
      chk($sformatf("vec%0d_c", i), 32'(dut8.c_flag), 32'(vt[i].c));
    end

    // OUT with three wait states, then a second OUT.
    clr8();
    rom8[0] = 16'h4140; rom8[1] = 16'h42A5; rom8[2] = 16'h5012;
    rom8[3] = 16'h4377; rom8[4] = 16'h5013; rom8[5] = 16'h1000;
    wait8 = 3;
    run8(200, cyc);
    wait8 = 0;
    chk("out_wait_cycles", 32'(cyc), 32'd20);
    chk("out_wait_nwrites", 32'(xq8.size()), 32'd2);
    if (xq8.size() >= 2) begin
      chk("out_wait_first", {xq8[0].addr, xq8[0].data}, 32'h004000A5);
      chk("out_wait_len", 32'(xq8[0].len), 32'd4);
      chk("out_wait_stable", {31'd0, xq8[0].stable}, 32'h1);
      chk("out_wait_is_write", {31'd0, xq8[0].wr}, 32'h1);
      chk("out_wait_second", {xq8[1].addr, xq8[1].data}, 32'h00400077);
    end

    // IN from 0x10 with immediate ready, echoed via OUT to 0x11.
    clr8();
    rom8[0] = 16'h4510; rom8[1] = 16'h6450; rom8[2] = 16'h4611;
    rom8[3] = 16'h5064; rom8[4] = 16'h1000;
    run8(200, cyc);
    chk("in_cycles", 32'(cyc), 32'd12);
    chk("in_nxfers", 32'(xq8.size()), 32'd2);
    if (xq8.size() >= 2) begin
      chk("in_read", {15'd0, xq8[0].wr, xq8[0].addr}, 32'h00000010);
      chk("in_read_len", 32'(xq8[0].len), 32'd1);
      chk("in_echo", {xq8[1].addr, xq8[1].data}, 32'h0011003C);
    end

    // Four nested calls then four returns.
    clr8();
    rom8[0]  = 16'hC00A; rom8[1]  = 16'h4201; rom8[2]  = 16'h5012; rom8[3]  = 16'h1000;
    rom8[10] = 16'hC014; rom8[11] = 16'h4202; rom8[12] = 16'h5012; rom8[13] = 16'h300F;
    rom8[20] = 16'hC01E; rom8[21] = 16'h4203; rom8[22] = 16'h5012; rom8[23] = 16'h300F;
    rom8[30] = 16'hC028; rom8[31] = 16'h4204; rom8[32] = 16'h5012; rom8[33] = 16'h300F;
    rom8[40] = 16'h4150; rom8[41] = 16'h300F;
    run8(300, cyc);
    chk("nest_halt_fault", {30'd0, halt8, fault8}, 32'h2);
    chk("nest_nwrites", 32'(xq8.size()), 32'd4);
    if (xq8.size() >= 4)
      for (int k = 0; k < 4; k++)
        chk($sformatf("nest_ret%0d", k), {xq8[k].addr, xq8[k].data}, {16'h0050, 16'(4 - k)});

    // Fifth call overflows.
    rom8[40] = 16'hC032;
    run8(300, cyc);
    chk("ovf_fault", {30'd0, halt8, fault8}, 32'h1);
    chk("ovf_cycles", 32'(cyc), 32'd10);
    chk("ovf_pc", 32'(ia8), 32'd40);
    repeat (5) @(negedge clk);
    chk("ovf_pc_frozen", 32'(ia8), 32'd40);
    chk("ovf_quiet", {29'd0, fault8, brd8, bwr8}, 32'h4);
    chk("ovf_nwrites", 32'(xq8.size()), 32'd0);

    // Return with an empty stack.
    clr8();
    rom8[0] = 16'h300F;
    run8(100, cyc);
    chk("unf_fault", {30'd0, halt8, fault8}, 32'h1);
    chk("unf_cycles", 32'(cyc), 32'd2);
    chk("unf_pc", 32'(ia8), 32'd0);

    // BNZ to 0xFFE, call from 0xFFF returns to 0, BNZ then falls through.
    clr8();
    rom8[0] = 16'hFFFE; rom8[1] = 16'h4160; rom8[2] = 16'h5011; rom8[3] = 16'h1000;
    rom8[100] = 16'h300F; rom8[4094] = 16'hB300; rom8[4095] = 16'hC064;
    run8(200, cyc);
    chk("wrap_halt", 32'(halt8), 32'h1);
    chk("wrap_cycles", 32'(cyc), 32'd17);
    chk("wrap_nwrites", 32'(xq8.size()), 32'd1);
    if (xq8.size() >= 1)
      chk("wrap_write", {xq8[0].addr, xq8[0].data}, 32'h00600060);
    n = xq8.size();
    repeat (6) @(negedge clk);
    chk("halt_quiet", {29'd0, halt8, brd8, bwr8}, 32'h4);
    chk("halt_no_xfer", 32'(xq8.size()), 32'(n));
    chk("one_strobe8", {31'd0, both8}, 32'h0);

    // 16-bit: zero extension, 0xFFFF + 1, BNZ not taken.
    rom16[0] = 16'h41FF; rom16[1] = 16'h4930; rom16[2] = 16'h5091; rom16[3] = 16'h3213;
    for (int k = 4; k <= 10; k++) rom16[k] = 16'h3223;
    rom16[11] = 16'h9321; rom16[12] = 16'h5093; rom16[13] = 16'h4401; rom16[14] = 16'hB534;
    rom16[15] = 16'h5095; rom16[16] = 16'hF013; rom16[17] = 16'h4601; rom16[18] = 16'hD014;
    rom16[19] = 16'h4600; rom16[20] = 16'h5096; rom16[21] = 16'h1000;
    run16(300, cyc);
    chk("w16_halt", 32'(halt16), 32'h1);
    chk("w16_cycles", 32'(cyc), 32'd46);
    chk("w16_nwrites", 32'(xq16.size()), 32'd4);
    if (xq16.size() >= 4) begin
      chk("w16_li_zext", {xq16[0].addr, xq16[0].data}, 32'h003000FF);
      chk("w16_ffff", {xq16[1].addr, xq16[1].data}, 32'h0030FFFF);
      chk("w16_add_wrap", {xq16[2].addr, xq16[2].data}, 32'h00300000);
      chk("w16_z", {xq16[3].addr, xq16[3].data}, 32'h00300001);
    end
    chk("w16_c", 32'(dut16.c_flag), 32'h1);

    // Reset in the middle of a stalled OUT.
    clr16();
    rom16[0] = 16'h4A31; rom16[1] = 16'h4B5A; rom16[2] = 16'h50AB; rom16[3] = 16'h1000;
    wait16 = 50;
    rst16 = 1'b1;
    repeat (2) @(negedge clk);
    rst16 = 1'b0;
    cyc = 0;
    while (cyc < 40 && !bwr16) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstbus_write_seen", 32'(bwr16), 32'h1);
    chk("rstbus_addr_data", {16'(ba16), bdo16}, 32'h0031005A);
    repeat (2) @(negedge clk);
    chk("rstbus_still_waiting", 32'(bwr16), 32'h1);
    rst16 = 1'b1;
    @(negedge clk);
    chk("rstbus_strobes", {30'd0, brd16, bwr16}, 32'h0);
    chk("rstbus_outputs", {16'(ba16), bdo16}, 32'h0);
    chk("rstbus_halt_fault", {30'd0, halt16, fault16}, 32'h0);
    wait16 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/risc_cpu_p.md
# risc_cpu_p

Parametrised second-generation controller core: a two-phase (fetch/execute) 16-bit-instruction processor with configurable data width, bus address width and hardware return-stack depth. It adds a ready-handshaked I/O bus with wait states, carry/zero flags, a multi-level call stack with overflow/underflow fault, and an explicit HALT. It sits between an external synchronous program ROM and the peripheral bus.

## Interface
- DATA_W, 8: register and bus data width (8..16); immediates zero-extended.
- ADDR_W, 8: bus address width (≤ DATA_W); address = rs1[ADDR_W-1:0].
- STACK_DEPTH, 4: return-stack entries (1..16).
- i_clk  in  1  clock; all logic rising-edge.
- i_rst  in  1  reset, synchronous, active-high.
- o_imem_addr  out  12  program address (= pc).
- i_imem_data  in  16  instruction; valid one cycle after o_imem_addr.
- o_bus_address  out  ADDR_W  I/O address.
- o_bus_data  out  DATA_W  write data.
- i_bus_data  in  DATA_W  read data, sampled when i_bus_ready=1.
- o_bus_read  out  1  read strobe.
- o_bus_write  out  1  write strobe.
- i_bus_ready  in  1  transfer completes in cycle sampled high.
- o_halt  out  1  HALT executed.
- o_fault  out  1  return-stack overflow/underflow.

## Operation
- Fields: cls=[15:14], sub=[13:12], rd=[11:8], rs1=[7:4], rs2=[3:0], imm=[7:0], tgt=[11:0]. 16 registers r0..r15, all general-purpose.
- cls 00: sub 00 NOP; sub 01 HALT; sub 10 NOP; sub 11 unary on rs1→rd by [3:0]: 0 SHL, 1 SHR (logical), 2 ROL, 3 ROR, F RET, others NOP. Unary ops leave flags unchanged.
- cls 01: sub 00 LI rd←imm; sub 01 OUT addr=rs1, data=rs2; sub 10 IN rd←bus at rs1; sub 11 NOP.
- cls 10: rd←rs1 op rs2: 00 XOR, 01 OR, 10 AND, 11 ADD (mod 2^DATA_W). Z←(result==0); C←ADD carry-out, C←0 for logic ops.
- cls 11: 00 JSR (push pc+1, pc←tgt), 01 JMP, 10 BEQ (if Z), 11 BNZ (if !Z).
- Return stack: sp counts 0..STACK_DEPTH. JSR with sp==STACK_DEPTH or RET with sp==0 → FAULT; no push/pop, pc frozen.
- PC 12-bit, wraps 4095→0; pc+1 pushed by JSR at 4095 is 0.
- States: FETCH→EXEC; EXEC→FETCH (non-bus), →BUS (IN/OUT), →HALT, →FAULT. BUS→FETCH when i_bus_ready=1, else stay. HALT, FAULT terminal until i_rst.
- Reset: pc=0, sp=0, all registers 0, Z=0, C=0, state FETCH; o_bus_read/o_bus_write/o_halt/o_fault=0; o_bus_address/o_bus_data=0.

## Timing
- Non-bus instruction: 2 cycles (FETCH, EXEC); rd/flags/pc/sp update at EXEC end edge. Register write visible to next instruction's EXEC (no hazard).
- Bus instruction: ≥3 cycles. Strobe, address and data are registered, asserted from first BUS cycle, held stable until the cycle with i_bus_ready=1 inclusive, deasserted next cycle. IN writes rd at that edge. Exactly one strobe asserted; never both.
- i_bus_ready ignored outside BUS.
- o_halt/o_fault rise the cycle after the offending EXEC, stay high; strobes stay 0 in HALT/FAULT.
- i_rst during BUS drops strobes the next cycle; no register write occurs.

## Test plan
- LI r1,0x05; LI r2,0xFB; ADD r3,r1,r2 → r3=0x00, Z=1, C=1; BEQ taken.
- OUT rs1=r1(0x40) rs2=r2(0xA5), ready held low 3 cycles → o_bus_write high 4 cycles, address 0x40, data 0xA5 stable; next fetch follows.
- IN from 0x10 returning 0x3C with immediate ready → r4=0x3C, instruction takes 3 cycles.
- Nested JSR to STACK_DEPTH then RETs → correct return addresses; one extra JSR → o_fault=1, pc frozen; fresh run with RET at sp=0 → o_fault=1.
- ROR 0x01 → 0x80, SHR 0x80 → 0x40, flags unchanged; HALT → o_halt=1, no further fetch-dependent activity.
- DATA_W=16: LI zero-extends 0xFF→0x00FF; ADD 0xFFFF+0x0001 → 0x0000, Z=1, C=1; i_rst mid-BUS clears all outputs.
